alu_mul_sequencer: RTL and testbench

- Controller in front of the 24-bit ALU result mux.
- Passes single-cycle ops (AND/OR/ADD/SLT/XOR/SLL) straight through to the mux select.
- Runs MUL as an iterative shift-add over several cycles, asserting `stall` to freeze PC/register-file writes until the product is ready.
- Flags the unused select code 3'b111 so the mux never sees an undefined select.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/shift_add_mul_core.sv | 76 +++++++
 rtl/alu_mul_sequencer.sv | 126 ++++++++++++
 tb/tb_alu_mul_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result-mux controller.
// Holds the ALU function codes, the sequencer state encoding and the
// default datapath width. Imported by the sequencer and its multiply core.
package alu_pkg;

  localparam int ALU_WIDTH = 24;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_mul_core.sv
// Iterative unsigned shift-add multiplier datapath.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   load            : capture a (multiplicand) and b (multiplier), clear acc
//   step            : consume one multiplier bit
//   a, b            : operands, sampled on load
//   last            : the step taken this cycle is the final one
//   product         : full 2*WIDTH-bit accumulator
module shift_add_mul_core
  import alu_pkg::*;
#(
  parameter int WIDTH      = ALU_WIDTH,
  parameter int EARLY_EXIT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 last,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] acc_reg,    acc_next;
  logic [2*WIDTH-1:0] mcand_reg,  mcand_next;
  logic [WIDTH-1:0]   mplier_reg, mplier_next;
  logic [CW-1:0]      count_reg,  count_next;
  logic [WIDTH-1:0]   mplier_shifted;

  assign mplier_shifted = mplier_reg >> 1;

  // Early exit looks at the multiplier after this step's shift, so the
  // last useful bit is still accumulated on the exiting cycle.
  assign last = (count_reg == CW'(WIDTH - 1)) ||
                ((EARLY_EXIT != 0) && (mplier_shifted == '0));

  assign product = acc_reg;

  always_comb begin
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    count_next  = count_reg;
    if (load) begin
      acc_next    = '0;
      mcand_next  = {{WIDTH{1'b0}}, a};
      mplier_next = b;
      count_next  = '0;
    end else if (step) begin
      if (mplier_reg[0]) begin
        acc_next = acc_reg + mcand_reg;
      end
      mcand_next  = mcand_reg << 1;
      mplier_next = mplier_shifted;
      count_next  = count_reg + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
    end else begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Controller in front of the ALU result mux.
// Single-cycle ops pass straight to mux_sel; MUL runs on the shift-add core
// with stall held until the product is ready; code 111 is flagged and never
// reaches the mux.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   op_valid        : instruction uses the ALU
//   alu_op          : ALU function code
//   a, b            : multiplicand / multiplier
//   mux_sel         : result-mux select
//   mul_result      : low WIDTH bits of the product
//   mul_ovf         : product high half nonzero
//   stall           : freeze PC / register-file writes
//   result_valid    : mux output is correct this cycle
//   illegal_op      : one-cycle flag for alu_op=111 with op_valid
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH      = ALU_WIDTH,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       mux_sel,
  output logic [WIDTH-1:0] mul_result,
  output logic             mul_ovf,
  output logic             stall,
  output logic             result_valid,
  output logic             illegal_op
);

  state_t state_reg, state_next;

  logic               core_load;
  logic               core_step;
  logic               core_last;
  logic [2*WIDTH-1:0] core_product;

  shift_add_mul_core #(
    .WIDTH      (WIDTH),
    .EARLY_EXIT (EARLY_EXIT)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (core_load),
    .step    (core_step),
    .a       (a),
    .b       (b),
    .last    (core_last),
    .product (core_product)
  );

  // The accumulator is left untouched after DONE, so these hold until the
  // next MUL is accepted.
  assign mul_result = core_product[WIDTH-1:0];
  assign mul_ovf    = |core_product[2*WIDTH-1:WIDTH];

  always_comb begin
    state_next   = state_reg;
    mux_sel      = OP_AND;
    stall        = 1'b0;
    result_valid = 1'b0;
    illegal_op   = 1'b0;
    core_load    = 1'b0;
    core_step    = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (op_valid) begin
          if (alu_op == OP_MUL) begin
            stall     = 1'b1;
            mux_sel   = OP_MUL;
            core_load = 1'b1;
            // A zero multiplier already has its product (0) after the load.
            state_next = ((EARLY_EXIT != 0) && (b == '0)) ? ST_DONE : ST_RUN;
          end else if (alu_op == OP_ILL) begin
            illegal_op = 1'b1;
          end else begin
            mux_sel      = alu_op;
            result_valid = 1'b1;
          end
        end
      end
      ST_RUN: begin
        stall     = 1'b1;
        mux_sel   = OP_MUL;
        core_step = 1'b1;
        if (core_last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        mux_sel      = OP_MUL;
        result_valid = 1'b1;
        state_next   = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Reset is synchronous, but the pipeline must not see stall or a valid
    // result while it is asserted.
    if (reset) begin
      mux_sel      = OP_AND;
      stall        = 1'b0;
      result_valid = 1'b0;
      illegal_op   = 1'b0;
      core_load    = 1'b0;
      core_step    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;
  import alu_pkg::*;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         reset;
  logic         op_valid;
  logic [2:0]   alu_op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   mux_sel;
  logic [W-1:0] mul_result;
  logic         mul_ovf;
  logic         stall;
  logic         result_valid;
  logic         illegal_op;

  alu_mul_sequencer #(.WIDTH(W), .EARLY_EXIT(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .op_valid     (op_valid),
    .alu_op       (alu_op),
    .a            (a),
    .b            (b),
    .mux_sel      (mux_sel),
    .mul_result   (mul_result),
    .mul_ovf      (mul_ovf),
    .stall        (stall),
    .result_valid (result_valid),
    .illegal_op   (illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [2:0]   sel;
    logic         ill;
    logic [W-1:0] res;
    logic         ovf;
    int           stalls;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           failures = 0;
  int           txn = 0;
  logic [W-1:0] model_res = '0;
  logic         model_ovf = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Number of RUN cycles with early exit: one per bit up to the highest set bit.
  function automatic int run_len(input logic [W-1:0] m);
    for (int i = W - 1; i >= 0; i--) begin
      if (m[i]) return i + 1;
    end
    return 0;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    logic [2*W-1:0] p;
    int n;
    bit fin;
    op_valid = 1'b1;
    alu_op   = op;
    a        = av;
    b        = bv;
    e.op = op;
    if (op == OP_MUL) begin
      p = {{W{1'b0}}, av} * {{W{1'b0}}, bv};
      model_res = p[W-1:0];
      model_ovf = (p[2*W-1:W] != '0);
      e.sel = OP_MUL; e.ill = 1'b0; e.stalls = 1 + run_len(bv);
    end else if (op == OP_ILL) begin
      e.sel = OP_AND; e.ill = 1'b1; e.stalls = 0;
    end else begin
      e.sel = op; e.ill = 1'b0; e.stalls = 0;
    end
    e.res = model_res;
    e.ovf = model_ovf;
    sb.push_back(e);
    $display("txn %0d: op=%0d a=0x%06h b=0x%06h exp_sel=%0d exp_res=0x%06h exp_ovf=%0b exp_stalls=%0d",
             txn, op, av, bv, e.sel, e.res, e.ovf, e.stalls);
    txn++;
    n = 0;
    fin = 0;
    while (!fin) begin
      @(negedge clk);
      if (!stall) fin = 1;
      else begin
        n++;
        if (n > 40) begin
          checks++;
          failures++;
          $display("FAIL stall_timeout actual=%0d cycles required<=40", n);
          fin = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    alu_op   = 3'($urandom());
    a        = W'($urandom());
    b        = W'($urandom());
  endtask

  // Monitor: counts stall cycles and checks each presented result against
  // the oldest outstanding expectation.
  initial begin
    int   stall_cnt;
    exp_t e;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_cnt = 0;
      end else begin
        if (stall) stall_cnt++;
        if (result_valid || illegal_op) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual rv=%0b ill=%0b required none", result_valid, illegal_op);
          end else begin
            e = sb.pop_front();
            chk("mux_sel",      64'(mux_sel),      64'(e.sel));
            chk("illegal_op",   64'(illegal_op),   64'(e.ill));
            chk("result_valid", 64'(result_valid), 64'(!e.ill));
            chk("stall_cycles", 64'(stall_cnt),    64'(e.stalls));
            chk("mul_result",   64'(mul_result),   64'(e.res));
            chk("mul_ovf",      64'(mul_ovf),      64'(e.ovf));
          end
          stall_cnt = 0;
        end
      end
    end
  end

  initial begin
    logic [W-1:0] ra, rb;
    int           mode;
    reset    = 1'b1;
    op_valid = 1'b0;
    alu_op   = OP_AND;
    a        = '0;
    b        = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall",   64'(stall),        64'(0));
    chk("rst_rv",      64'(result_valid), 64'(0));
    chk("rst_ill",     64'(illegal_op),   64'(0));
    chk("rst_sel",     64'(mux_sel),      64'(0));
    chk("rst_mulres",  64'(mul_result),   64'(0));
    chk("rst_mulovf",  64'(mul_ovf),      64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_stall", 64'(stall),        64'(0));
    chk("idle_rv",    64'(result_valid), 64'(0));
    @(posedge clk);
    #1;

    // Directed cases
    issue(OP_ADD, 24'h000010, 24'h000020);
    issue(OP_MUL, 24'd3, 24'd5);
    issue(OP_MUL, 24'hFFFFFF, 24'hFFFFFF);
    issue(OP_MUL, 24'h123456, 24'h000000);
    issue(OP_ILL, 24'h000001, 24'h000002);
    issue(OP_SLL, 24'h000001, 24'h000003);

    // Reset in RUN cycle 10 aborts the multiply
    op_valid = 1'b1;
    alu_op   = OP_MUL;
    a        = 24'd7;
    b        = 24'h800000;
    repeat (10) @(posedge clk);
    #1;
    reset    = 1'b1;
    op_valid = 1'b0;
    @(negedge clk);
    chk("midrst_stall", 64'(stall),        64'(0));
    chk("midrst_rv",    64'(result_valid), 64'(0));
    chk("midrst_sel",   64'(mux_sel),      64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_res = '0;
    model_ovf = 1'b0;
    @(negedge clk);
    chk("postrst_stall",  64'(stall),        64'(0));
    chk("postrst_rv",     64'(result_valid), 64'(0));
    chk("postrst_mulres", 64'(mul_result),   64'(0));
    @(posedge clk);
    #1;
    issue(OP_ADD, 24'h000005, 24'h000006);

    // Back-to-back multiplies
    issue(OP_MUL, 24'h000ABC, 24'h000123);
    issue(OP_MUL, 24'h800000, 24'h000002);

    // Randomized mix
    for (int i = 0; i < 150; i++) begin
      ra   = W'($urandom());
      mode = int'($urandom_range(0, 3));
      case (mode)
        0:       rb = W'($urandom());
        1:       rb = W'($urandom_range(0, 255));
        2:       rb = '0;
        default: rb = W'(1) << $urandom_range(0, W - 1);
      endcase
      issue(3'($urandom_range(0, 7)), ra, rb);
      if ($urandom_range(0, 3) == 0) begin
        repeat (int'($urandom_range(1, 3))) @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=expired required=finish");
    $fatal(1, "timeout");
  end

endmodule
